// File: rtl/block_commit_tracker_pkg.sv
// Shared types and constants for the block commit tracker.
//   block_header_t : header fields consumed at allocation (store mask, register write count)
//   slot_state_t   : per-slot architectural output bookkeeping
//   lsid_bit()     : one-hot store mask bit for an LSID
package block_commit_tracker_pkg;

  localparam int unsigned MAX_INFLIGHT_BLOCKS = 8;
  localparam int unsigned TIMEOUT_CYC_DEFAULT = 1024;
  localparam int unsigned LSID_W              = 5;
  localparam int unsigned MAX_STORES          = 32;
  localparam int unsigned WR_CNT_W            = 5;

  typedef struct packed {
    logic [MAX_STORES-1:0] store_mask;
    logic [WR_CNT_W-1:0]   num_reg_writes;
  } block_header_t;

  typedef struct packed {
    logic                  valid;
    logic [MAX_STORES-1:0] exp_mask;
    logic [WR_CNT_W-1:0]   exp_wr;
    logic [MAX_STORES-1:0] st_rcv;
    logic [WR_CNT_W-1:0]   wr_cnt;
    logic                  br_rcv;
    logic                  taken;
    logic [LSID_W-1:0]     exit_id;
  } slot_state_t;

  function automatic logic [MAX_STORES-1:0] lsid_bit(input logic [LSID_W-1:0] lsid);
    return MAX_STORES'(1) << lsid;
  endfunction

endpackage

// File: rtl/block_commit_tracker_if.sv
// Bus between the block producer side (header path, output reports, flush)
// and the commit tracker.
//   master : drives alloc_valid/alloc_header, wr_*, st_*, br_*, flush;
//            observes alloc_ready/alloc_slot, commit_*, inflight_mask,
//            protocol_error, timeout_flush
//   slave  : the tracker, opposite directions
interface block_commit_tracker_if
  import block_commit_tracker_pkg::*;
#(
  parameter int unsigned N_SLOTS = MAX_INFLIGHT_BLOCKS
);
  localparam int unsigned SLOT_W = $clog2(N_SLOTS);

  logic                alloc_valid;
  block_header_t       alloc_header;
  logic                alloc_ready;
  logic [SLOT_W-1:0]   alloc_slot;

  logic                wr_valid;
  logic [SLOT_W-1:0]   wr_slot;
  logic                st_valid;
  logic [SLOT_W-1:0]   st_slot;
  logic [LSID_W-1:0]   st_lsid;
  logic                br_valid;
  logic [SLOT_W-1:0]   br_slot;
  logic                br_taken;
  logic [LSID_W-1:0]   br_exit_id;

  logic                flush;

  logic                commit;
  logic [SLOT_W-1:0]   commit_slot;
  logic                commit_taken;
  logic [LSID_W-1:0]   commit_exit_id;
  logic [N_SLOTS-1:0]  inflight_mask;
  logic                protocol_error;
  logic                timeout_flush;

  modport master (
    output alloc_valid, alloc_header,
    output wr_valid, wr_slot, st_valid, st_slot, st_lsid,
    output br_valid, br_slot, br_taken, br_exit_id, flush,
    input  alloc_ready, alloc_slot,
    input  commit, commit_slot, commit_taken, commit_exit_id,
    input  inflight_mask, protocol_error, timeout_flush
  );

  modport slave (
    input  alloc_valid, alloc_header,
    input  wr_valid, wr_slot, st_valid, st_slot, st_lsid,
    input  br_valid, br_slot, br_taken, br_exit_id, flush,
    output alloc_ready, alloc_slot,
    output commit, commit_slot, commit_taken, commit_exit_id,
    output inflight_mask, protocol_error, timeout_flush
  );

endinterface

// File: rtl/block_commit_tracker_slot.sv
// block_slot_tracker: bookkeeping for one in-flight block slot.
//   clear        : synchronous discard (reset or flush), highest priority
//   load/hdr     : allocate this slot with a new header
//   retire       : slot is being committed this cycle
//   wr_hit, st_hit/st_lsid, br_hit/br_taken/br_exit_id : output reports aimed at this slot
//   valid, complete, taken, exit_id : registered slot status
//   err          : a report aimed at this slot this cycle is illegal and is dropped
module block_slot_tracker
  import block_commit_tracker_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  block_header_t     hdr,
  input  logic              retire,
  input  logic              wr_hit,
  input  logic              st_hit,
  input  logic [LSID_W-1:0] st_lsid,
  input  logic              br_hit,
  input  logic              br_taken,
  input  logic [LSID_W-1:0] br_exit_id,
  output logic              valid,
  output logic              complete,
  output logic              taken,
  output logic [LSID_W-1:0] exit_id,
  output logic              err
);

  slot_state_t s_q;
  slot_state_t s_d;
  logic        wr_ok;
  logic        st_ok;
  logic        br_ok;

  always_comb begin
    wr_ok = wr_hit && s_q.valid && (s_q.wr_cnt != s_q.exp_wr);
    st_ok = st_hit && s_q.valid && s_q.exp_mask[st_lsid] && !s_q.st_rcv[st_lsid];
    br_ok = br_hit && s_q.valid && !s_q.br_rcv;
    err   = (wr_hit && !wr_ok) || (st_hit && !st_ok) || (br_hit && !br_ok);
  end

  // Reports arriving in the same cycle as retire are already illegal (the slot
  // is complete), so retire and accepted updates never overlap.
  always_comb begin
    s_d = s_q;
    if (load) begin
      s_d          = '0;
      s_d.valid    = 1'b1;
      s_d.exp_mask = hdr.store_mask;
      s_d.exp_wr   = hdr.num_reg_writes;
    end else begin
      if (retire) s_d.valid  = 1'b0;
      if (wr_ok)  s_d.wr_cnt = s_q.wr_cnt + WR_CNT_W'(1);
      if (st_ok)  s_d.st_rcv = s_q.st_rcv | lsid_bit(st_lsid);
      if (br_ok) begin
        s_d.br_rcv  = 1'b1;
        s_d.taken   = br_taken;
        s_d.exit_id = br_exit_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) s_q <= '0;
    else       s_q <= s_d;
  end

  assign valid    = s_q.valid;
  assign taken    = s_q.taken;
  assign exit_id  = s_q.exit_id;
  assign complete = s_q.valid && (s_q.st_rcv == s_q.exp_mask) &&
                    (s_q.wr_cnt == s_q.exp_wr) && s_q.br_rcv;

endmodule

// File: rtl/block_commit_tracker.sv
// block_commit_tracker: tracks architectural outputs of in-flight blocks and
// commits them strictly in allocation order, one per cycle.
//   clk  : clock
//   rst  : synchronous active-high reset (also clears protocol_error)
//   bus  : block_commit_tracker_if.slave (alloc, output reports, flush, commit, status)
// Optional feature: define COMMIT_TIMEOUT_EN to enable the commit watchdog
// (TIMEOUT_CYC parameter); otherwise timeout_flush is tied low.
module block_commit_tracker
  import block_commit_tracker_pkg::*;
#(
  parameter int unsigned N_SLOTS = MAX_INFLIGHT_BLOCKS
`ifdef COMMIT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  block_commit_tracker_if.slave bus
);

  localparam int unsigned SLOT_W = $clog2(N_SLOTS);

  logic [SLOT_W-1:0]  head_q;
  logic [SLOT_W-1:0]  tail_q;
  logic [SLOT_W:0]    count_q;
  logic               protocol_error_q;

  logic               flush_int;
  logic               tmo_fire;
  logic               alloc_fire;
  logic               commit_fire;

  logic [N_SLOTS-1:0] slot_valid;
  logic [N_SLOTS-1:0] slot_complete;
  logic [N_SLOTS-1:0] slot_taken;
  logic [N_SLOTS-1:0] slot_err;
  logic [LSID_W-1:0]  slot_exit [N_SLOTS];

  assign flush_int   = bus.flush || tmo_fire;
  // Ready is based on the registered count, so a slot freed by this cycle's
  // commit is not reusable until the next cycle.
  assign bus.alloc_ready = (count_q < (SLOT_W+1)'(N_SLOTS));
  assign alloc_fire  = bus.alloc_valid && bus.alloc_ready && !flush_int && !rst;
  assign commit_fire = slot_complete[head_q] && !flush_int && !rst;

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    block_slot_tracker u_slot (
      .clk        (clk),
      .clear      (rst || flush_int),
      .load       (alloc_fire && (tail_q == SLOT_W'(i))),
      .hdr        (bus.alloc_header),
      .retire     (commit_fire && (head_q == SLOT_W'(i))),
      .wr_hit     (bus.wr_valid && (bus.wr_slot == SLOT_W'(i)) && !flush_int),
      .st_hit     (bus.st_valid && (bus.st_slot == SLOT_W'(i)) && !flush_int),
      .st_lsid    (bus.st_lsid),
      .br_hit     (bus.br_valid && (bus.br_slot == SLOT_W'(i)) && !flush_int),
      .br_taken   (bus.br_taken),
      .br_exit_id (bus.br_exit_id),
      .valid      (slot_valid[i]),
      .complete   (slot_complete[i]),
      .taken      (slot_taken[i]),
      .exit_id    (slot_exit[i]),
      .err        (slot_err[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || flush_int) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc_fire)  tail_q <= tail_q + SLOT_W'(1);
      if (commit_fire) head_q <= head_q + SLOT_W'(1);
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + (SLOT_W+1)'(1);
        2'b01:   count_q <= count_q - (SLOT_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            protocol_error_q <= 1'b0;
    else if (|slot_err) protocol_error_q <= 1'b1;
  end

`ifdef COMMIT_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

  logic [TMO_W-1:0] tmo_cnt_q;

  assign tmo_fire = (count_q != '0) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || flush_int || commit_fire || (alloc_fire && (count_q == '0)))
      tmo_cnt_q <= '0;
    else if (count_q != '0)
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end
`else
  assign tmo_fire = 1'b0;
`endif

  assign bus.alloc_slot     = tail_q;
  assign bus.commit         = commit_fire;
  assign bus.commit_slot    = commit_fire ? head_q : '0;
  assign bus.commit_taken   = commit_fire && slot_taken[head_q];
  assign bus.commit_exit_id = commit_fire ? slot_exit[head_q] : '0;
  assign bus.inflight_mask  = slot_valid;
  assign bus.protocol_error = protocol_error_q;
  assign bus.timeout_flush  = tmo_fire;

endmodule
